// File: rtl/laser_pkg.sv
// Shared types and sizing for the LASER point feeder: frame geometry, stream states, result record.
package laser_pkg;
    localparam int OBJ_NUM = 40;
    localparam int COORD_W = 4;
    localparam int POINT_W = 2 * COORD_W;
    localparam int PTR_W   = $clog2(OBJ_NUM + 1);

    typedef enum logic [1:0] {
        WAIT_BANK = 2'd0,
        STREAM    = 2'd1,
        WAIT_DONE = 2'd2
    } stream_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] c1x;
        logic [COORD_W-1:0] c1y;
        logic [COORD_W-1:0] c2x;
        logic [COORD_W-1:0] c2y;
    } result_t;
endpackage

// File: rtl/laser_frame_bank.sv
// Two frames of OBJ_NUM points; one-cycle write, combinational read, no backpressure.
module laser_frame_bank
    import laser_pkg::*;
(
    input  logic               CLK,
    input  logic               wr_en,
    input  logic               wr_bank,
    input  logic [PTR_W-1:0]   wr_ptr,
    input  logic [POINT_W-1:0] wr_data,
    input  logic               rd_bank,
    input  logic [PTR_W-1:0]   rd_ptr,
    output logic [POINT_W-1:0] rd_data
);
    // Contents are only read from a bank flagged full, so no reset is needed.
    logic [POINT_W-1:0] mem [2][OBJ_NUM];

    always_ff @(posedge CLK) begin
        if (wr_en)
            mem[wr_bank][wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_bank][rd_ptr];
endmodule

// File: rtl/laser_point_feeder.sv
// Buffers host points into two frames and bursts them to the engine; burst starts one cycle after a
// frame completes. in_ready drops while both frames are full; results are held until res_ready.
module laser_point_feeder
    import laser_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    output logic               LRST,
    output logic [COORD_W-1:0] X,
    output logic [COORD_W-1:0] Y,
    input  logic               DONE,
    input  logic [COORD_W-1:0] C1X,
    input  logic [COORD_W-1:0] C1Y,
    input  logic [COORD_W-1:0] C2X,
    input  logic [COORD_W-1:0] C2Y,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [COORD_W-1:0] res_c1x,
    output logic [COORD_W-1:0] res_c1y,
    output logic [COORD_W-1:0] res_c2x,
    output logic [COORD_W-1:0] res_c2y,
    output logic               res_ovf,
    output logic [7:0]         frame_cnt
);
    stream_state_t      state;
    logic [1:0]         full;
    logic               wr_bank;
    logic               rd_bank;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   rd_addr;
    logic [POINT_W-1:0] rd_data;
    logic               accept;
    logic               wr_last;
    logic               rd_release;
    result_t            res;

    assign in_ready   = !full[wr_bank];
    assign accept     = in_valid && in_ready;
    assign wr_last    = accept && (wr_ptr == PTR_W'(OBJ_NUM - 1));
    assign rd_release = (state == STREAM) && (rd_ptr == PTR_W'(OBJ_NUM));
    // Outside an active burst the read port pre-fetches point 0 of the next frame.
    assign rd_addr    = (state == STREAM && !rd_release) ? rd_ptr : '0;

    laser_frame_bank u_bank (
        .CLK     (CLK),
        .wr_en   (accept),
        .wr_bank (wr_bank),
        .wr_ptr  (wr_ptr),
        .wr_data ({in_y, in_x}),
        .rd_bank (rd_bank),
        .rd_ptr  (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_bank <= 1'b0;
            wr_ptr  <= '0;
            full    <= 2'b00;
        end else begin
            if (accept) begin
                if (wr_last) begin
                    wr_ptr  <= '0;
                    wr_bank <= !wr_bank;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end
            // Release and fill always target different banks, so both may land together.
            if (rd_release)
                full[rd_bank] <= 1'b0;
            if (wr_last)
                full[wr_bank] <= 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= WAIT_BANK;
            LRST      <= 1'b1;
            X         <= '0;
            Y         <= '0;
            rd_bank   <= 1'b0;
            rd_ptr    <= '0;
            frame_cnt <= '0;
        end else begin
            case (state)
                WAIT_BANK: begin
                    if (full[rd_bank]) begin
                        LRST   <= 1'b0;
                        {Y, X} <= rd_data;
                        rd_ptr <= PTR_W'(1);
                        state  <= STREAM;
                    end
                end
                STREAM: begin
                    if (rd_release) begin
                        X         <= '0;
                        Y         <= '0;
                        rd_bank   <= !rd_bank;
                        frame_cnt <= frame_cnt + 8'd1;
                        state     <= WAIT_DONE;
                    end else begin
                        {Y, X} <= rd_data;
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (DONE) begin
                        if (full[rd_bank]) begin
                            {Y, X} <= rd_data;
                            rd_ptr <= PTR_W'(1);
                            state  <= STREAM;
                        end else begin
                            LRST  <= 1'b1;
                            state <= WAIT_BANK;
                        end
                    end
                end
                default: begin
                    LRST  <= 1'b1;
                    X     <= '0;
                    Y     <= '0;
                    state <= WAIT_BANK;
                end
            endcase
        end
    end

    // Results are captured on every DONE, even one the stream FSM treats as out of protocol.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            res       <= '0;
            res_valid <= 1'b0;
            res_ovf   <= 1'b0;
        end else begin
            if (DONE) begin
                res       <= {C1X, C1Y, C2X, C2Y};
                res_valid <= 1'b1;
                if (res_valid && !res_ready)
                    res_ovf <= 1'b1;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

    assign res_c1x = res.c1x;
    assign res_c1y = res.c1y;
    assign res_c2x = res.c2x;
    assign res_c2y = res.c2y;
endmodule

// File: tb/tb_laser_point_feeder.sv
// Directed bench for laser_point_feeder: frame fill, burst timing, back-to-back frames, result capture, reset.
module tb_laser_point_feeder;
    logic       CLK, RST;
    logic       in_valid, in_ready;
    logic [3:0] in_x, in_y;
    logic       LRST;
    logic [3:0] X, Y;
    logic       DONE;
    logic [3:0] C1X, C1Y, C2X, C2Y;
    logic       res_valid, res_ready;
    logic [3:0] res_c1x, res_c1y, res_c2x, res_c2y;
    logic       res_ovf;
    logic [7:0] frame_cnt;

    int n_vec  = 0;
    int n_fail = 0;

    laser_point_feeder dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .LRST(LRST), .X(X), .Y(Y),
        .DONE(DONE), .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_c1x(res_c1x), .res_c1y(res_c1y), .res_c2x(res_c2x), .res_c2y(res_c2y),
        .res_ovf(res_ovf), .frame_cnt(frame_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       done;
        logic [3:0] c1x, c1y, c2x, c2y;
        logic       rdy;
        logic       exp_vld;
        logic [3:0] e1x, e1y, e2x, e2y;
        logic       exp_ovf;
        logic       exp_lrst;
    } res_vec_t;

    res_vec_t rtab [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [3:0] px(input int f, input int i);
        return 4'((i + 3 * f) % 16);
    endfunction

    function automatic logic [3:0] py(input int f, input int i);
        return 4'((i / 16 + f) % 16);
    endfunction

    task automatic load_frame(input int f, input bit gap, input bit chk_rdy);
        int t;
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'b1;
            in_x     = px(f, i);
            in_y     = py(f, i);
            if (chk_rdy) check("fill_in_ready", in_ready, 1);
            t = 0;
            while (!in_ready && t < 200) begin
                step();
                t++;
            end
            if (t >= 200) begin
                check("in_ready_timeout", in_ready, 1);
                in_valid = 1'b0;
                return;
            end
            step();
            if (gap && i < 39) begin
                in_valid = 1'b0;
                step();
            end
        end
        in_valid = 1'b0;
    endtask

    // Caller is positioned on the cycle that should carry point 0.
    task automatic burst_check(input int f, input int exp_cnt);
        for (int i = 0; i < 40; i++) begin
            check("burst_lrst", LRST, 0);
            check("burst_x", X, px(f, i));
            check("burst_y", Y, py(f, i));
            step();
        end
        check("end_x", X, 0);
        check("end_y", Y, 0);
        check("end_lrst", LRST, 0);
        check("frame_cnt", frame_cnt, exp_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rtab[0] = '{1'b1, 4'd3, 4'd4, 4'd11, 4'd12, 1'b0, 1'b1, 4'd3, 4'd4, 4'd11, 4'd12, 1'b0, 1'b1};
        rtab[1] = '{1'b0, 4'd0, 4'd0, 4'd0,  4'd0,  1'b0, 1'b1, 4'd3, 4'd4, 4'd11, 4'd12, 1'b0, 1'b1};
        rtab[2] = '{1'b1, 4'd5, 4'd6, 4'd7,  4'd8,  1'b0, 1'b1, 4'd5, 4'd6, 4'd7,  4'd8,  1'b1, 1'b1};
        rtab[3] = '{1'b0, 4'd0, 4'd0, 4'd0,  4'd0,  1'b1, 1'b0, 4'd5, 4'd6, 4'd7,  4'd8,  1'b1, 1'b1};
        rtab[4] = '{1'b1, 4'd1, 4'd2, 4'd9,  4'd10, 1'b1, 1'b1, 4'd1, 4'd2, 4'd9,  4'd10, 1'b1, 1'b1};
        rtab[5] = '{1'b1, 4'd15, 4'd14, 4'd13, 4'd0, 1'b1, 1'b1, 4'd15, 4'd14, 4'd13, 4'd0, 1'b1, 1'b1};
        rtab[6] = '{1'b0, 4'd0, 4'd0, 4'd0,  4'd0,  1'b1, 1'b0, 4'd15, 4'd14, 4'd13, 4'd0, 1'b1, 1'b1};

        RST = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0;
        DONE = 1'b0; C1X = '0; C1Y = '0; C2X = '0; C2Y = '0; res_ready = 1'b0;
        step();
        check("rst_lrst", LRST, 1);
        check("rst_x", X, 0);
        check("rst_y", Y, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_ovf", res_ovf, 0);
        check("rst_res_c1x", res_c1x, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        step();
        RST = 1'b0;

        // First frame: LRST drops one cycle after the 40th accept.
        load_frame(0, 1'b0, 1'b1);
        check("lrst_at_last_accept", LRST, 1);
        step();
        burst_check(0, 1);

        // DONE with no frame queued returns to reset; later rows are out-of-protocol DONEs.
        for (int r = 0; r < 7; r++) begin
            DONE = rtab[r].done;
            C1X = rtab[r].c1x; C1Y = rtab[r].c1y; C2X = rtab[r].c2x; C2Y = rtab[r].c2y;
            res_ready = rtab[r].rdy;
            step();
            check("res_valid", res_valid, rtab[r].exp_vld);
            check("res_c1x", res_c1x, rtab[r].e1x);
            check("res_c1y", res_c1y, rtab[r].e1y);
            check("res_c2x", res_c2x, rtab[r].e2x);
            check("res_c2y", res_c2y, rtab[r].e2y);
            check("res_ovf", res_ovf, rtab[r].exp_ovf);
            check("res_lrst", LRST, rtab[r].exp_lrst);
        end
        DONE = 1'b0; res_ready = 1'b0;

        // Host pauses every other cycle; burst must still be contiguous and in order.
        load_frame(1, 1'b1, 1'b1);
        check("lrst_gap_last_accept", LRST, 1);
        step();
        burst_check(1, 2);

        DONE = 1'b1;
        step();
        DONE = 1'b0;
        check("lrst_done_no_bank", LRST, 1);

        // Frames A and B back-to-back; third frame blocked until A releases.
        load_frame(2, 1'b0, 1'b1);
        load_frame(3, 1'b0, 1'b1);
        check("in_ready_both_full", in_ready, 0);
        check("a_last_point_x", X, px(2, 39));
        check("a_last_point_y", Y, py(2, 39));
        step();
        check("in_ready_after_release", in_ready, 1);
        check("wait_done_x", X, 0);
        check("wait_done_lrst", LRST, 0);
        check("frame_cnt_a", frame_cnt, 3);
        DONE = 1'b1;
        step();
        DONE = 1'b0;
        burst_check(3, 4);

        // Reset in the middle of a burst.
        load_frame(4, 1'b0, 1'b1);
        DONE = 1'b1;
        step();
        DONE = 1'b0;
        repeat (19) step();
        check("mid_burst_x", X, px(4, 19));
        #2;
        RST = 1'b1;
        #1;
        check("arst_lrst", LRST, 1);
        check("arst_x", X, 0);
        check("arst_y", Y, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_frame_cnt", frame_cnt, 0);
        check("arst_res_valid", res_valid, 0);
        step();
        RST = 1'b0;
        load_frame(5, 1'b0, 1'b1);
        check("lrst_after_reset_fill", LRST, 1);
        step();
        burst_check(5, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/laser_point_feeder.md
Name: laser_point_feeder

Overview:
- Upstream stage of the LASER circle-placement engine.
- Accepts object points from a host over a valid/ready stream and stores them in a double-buffered 40-entry frame memory.
- Drives the engine's X/Y inputs in the exact 40-cycle burst the engine samples, and gates the engine's reset so a burst never starts on an incomplete frame.
- Captures the engine's C1/C2 result on DONE and returns it to the host via a valid/ready result port.

Parameters:
- OBJ_NUM, 40, points per frame; the engine samples exactly this many.
- COORD_W, 4, width of one coordinate.

Ports:
- CLK  in  1  clock
- RST  in  1  reset; asynchronous, active-high
- in_valid  in  1  host point valid
- in_ready  out  1  feeder can accept a point
- in_x  in  COORD_W  point X
- in_y  in  COORD_W  point Y
- LRST  out  1  synchronous reset driven to the engine, active-high, registered
- X  out  COORD_W  point X to engine, registered
- Y  out  COORD_W  point Y to engine, registered
- DONE  in  1  engine result strobe, high for one cycle
- C1X, C1Y, C2X, C2Y  in  COORD_W each  engine result, valid while DONE=1
- res_valid  out  1  captured result pending
- res_ready  in  1  host takes result
- res_c1x, res_c1y, res_c2x, res_c2y  out  COORD_W each  captured result
- res_ovf  out  1  sticky: a result was overwritten before the host took it
- frame_cnt  out  8  frames streamed, wraps 255->0

Behaviour:
- Reset (async): state WAIT_BANK; LRST=1; X=Y=0; both banks empty; wr_bank=rd_bank=0; wr_ptr=rd_ptr=0; res_valid=0; res_* = 0; res_ovf=0; frame_cnt=0.
- Fill side:
  - in_ready = !full[wr_bank] (combinational). A point is accepted on in_valid && in_ready and written to mem[wr_bank][wr_ptr] as {y,x}.
  - On the 40th accept: full[wr_bank]<=1, wr_bank toggles, wr_ptr<=0.
  - With both banks full, in_ready=0 until a bank is released.
- Stream FSM:
  - WAIT_BANK: LRST=1, X=Y=0. If full[rd_bank], then at this edge: LRST<=0, X/Y<=point 0, rd_ptr<=1, go to STREAM.
  - STREAM: each edge with rd_ptr<40 drives point rd_ptr and increments rd_ptr. This yields exactly 40 consecutive cycles with LRST=0 carrying points 0..39 in order. At the edge where rd_ptr==40: X=Y<=0, full[rd_bank]<=0, rd_bank toggles, frame_cnt++, go to WAIT_DONE.
  - WAIT_DONE: hold LRST=0 and X=Y=0. When DONE=1:
    - if full[rd_bank]: drive point 0 in the next cycle, rd_ptr<=1, go to STREAM, LRST stays 0. The engine's IDLE->READ step makes it sample that cycle.
    - else: LRST<=1, go to WAIT_BANK.
  - DONE in WAIT_BANK or STREAM is a protocol error; it is ignored by the FSM but still captured as a result.
- Result capture:
  - On DONE=1: res_* <= C*, res_valid<=1.
  - If res_valid && !res_ready in the same cycle, res_ovf<=1 (sticky until RST).
  - res_valid clears on res_valid && res_ready with no concurrent DONE. If both occur, the new result is loaded and res_valid stays 1.
- Simultaneous events:
  - A bank release and the last write of the other bank in the same cycle are legal. A bank is never written while full, and never read unless full.
  - A fill completing in the same cycle WAIT_BANK checks full takes effect next cycle (one-cycle latency from 40th accept to the LRST drop).
- Reset mid-operation aborts the burst. LRST goes high asynchronously and all frame data is discarded.

Decomposition:
- Package laser_pkg: OBJ_NUM, COORD_W, POINT_W = 2*COORD_W, stream state encoding (WAIT_BANK, STREAM, WAIT_DONE), result struct {c1x,c1y,c2x,c2y}.
- One sub-module, laser_frame_bank: 2 x OBJ_NUM x POINT_W storage with write port (bank, ptr, data, en) and asynchronous read port (bank, ptr).
- FSM and result capture stay in the top.

Test Plan:
- Reset, then 40 points (x=i%16, y=i/16) with in_valid held high → in_ready high for 40 cycles. LRST falls 1 cycle after the 40th accept. X/Y equal points 0..39 over the next 40 cycles, then 0. frame_cnt=1.
- Load frames A and B back-to-back, no gaps → third-frame in_ready=0 until A's burst ends. DONE pulse → B's point 0 appears the next cycle with LRST held 0.
- Frame B not loaded when DONE arrives → LRST=1 the next cycle. Completing B's 40th point → LRST falls one cycle later and the burst starts.
- DONE with C1=(3,4), C2=(11,12), res_ready=0 → res_valid=1 with those values. A second DONE before res_ready → new values, res_ovf=1.
- Assert RST at rd_ptr=20 → LRST=1, X=Y=0, in_ready=1, frame_cnt=0 immediately. A fresh 40-point load streams from point 0.
- Host in_valid toggling every other cycle → bank still fills in order. X/Y burst content is unchanged and contiguous.
